delay_line_controller: RTL and testbench
========================================

Name: delay_line_controller

Overview:
- Configuration sequencer and valid-tracking companion for the variable shift-register delay line.
- Accepts delay-change requests over a valid/ready handshake and drives the delay line's DELAY input.
- After every change, blanks output validity until the line has refilled with samples taken under the new delay.
- Carries a per-sample valid tag alongside the data path so downstream logic sees DOUT_VALID aligned with DOUT.

Parameters:
- MAX_DELAY_LENGTH, 16: depth of the controlled delay line; DELAY width DW = $clog2(MAX_DELAY_LENGTH).
- DEFAULT_DELAY, 1: delay applied after reset; legal range 1..MAX_DELAY_LENGTH-1.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST_N  in  1  asynchronous reset, active-low.
- CFG_DELAY  in  DW  requested delay in cycles.
- CFG_VALID  in  1  request strobe; holds CFG_DELAY stable until accepted.
- CFG_READY  out  1  controller can accept a request.
- CFG_ERR  out  1  one-cycle pulse: request accepted but rejected as illegal (value 0).
- DIN_VALID  in  1  valid tag for the sample entering the delay line this cycle.
- DELAY  out  DW  delay value driven to the delay line.
- DOUT_VALID  out  1  tag aligned with the delay line's DOUT.
- BUSY  out  1  high while not in RUN.

Behaviour:
- Reset (RST_N low, asynchronous):
  - DELAY = DEFAULT_DELAY; CFG_READY = 0; CFG_ERR = 0; DOUT_VALID = 0; BUSY = 1.
  - Valid shift register cleared; settle counter = 0; state = SETTLE.
- Alignment contract: the delay line presents at DOUT the DIN sampled DELAY posedges earlier.
  - Valid register vsr[MAX_DELAY_LENGTH-1:0]: vsr[0] <= DIN_VALID, vsr[i] <= vsr[i-1] every cycle, in every state.
  - Raw tag = vsr[DELAY-1].
- States:
  - SETTLE:
    - CFG_READY = 0; BUSY = 1; DOUT_VALID = 0.
    - Counter increments each cycle; when counter == DELAY-1, next state is RUN and the counter clears.
    - After reset, exactly DEFAULT_DELAY cycles are spent in SETTLE.
  - RUN:
    - CFG_READY = 1; BUSY = 0; DOUT_VALID = raw tag (combinational from registered state).
    - On CFG_VALID & CFG_READY at edge k with CFG_DELAY in 1..MAX_DELAY_LENGTH-1:
      - DELAY takes the new value at edge k.
      - State becomes SETTLE with counter = 0; DOUT_VALID is low from cycle k+1.
      - Exactly new-DELAY cycles of blanking follow, then DOUT_VALID resumes.
    - On CFG_VALID & CFG_READY with CFG_DELAY == 0:
      - Request is consumed; CFG_ERR pulses high for the cycle after edge k.
      - DELAY unchanged; state stays RUN; DOUT_VALID is not interrupted.
    - Request equal to the current DELAY: treated as a change; full SETTLE is performed.
- Handshake:
  - Transfer occurs only when CFG_VALID & CFG_READY at a posedge.
  - CFG_VALID during SETTLE is held off (CFG_READY = 0), never dropped or queued.
- Reset mid-SETTLE or mid-RUN:
  - Immediate return to reset values.
  - Any pending request is discarded; the requester must re-present it.
- The valid register shifts during SETTLE, so tags are correct on the first RUN cycle.
  - Blanking is therefore the only source of DOUT_VALID = 0 beyond genuine DIN_VALID gaps.
- The counter width is DW; it never exceeds MAX_DELAY_LENGTH-2.

Test Plan:
- Reset release, DEFAULT_DELAY = 1, DIN_VALID = 1 continuous:
  - BUSY high 1 cycle, then CFG_READY = 1.
  - DOUT_VALID = 1 from the next cycle.
  - DOUT matches DIN sampled 1 cycle earlier.
- In RUN, request CFG_DELAY = 5:
  - DELAY = 5 after the accepting edge.
  - DOUT_VALID low for exactly 5 cycles, then high.
  - First valid DOUT equals the DIN sampled 5 cycles earlier.
- DIN_VALID pattern 1,0,1,1 at delay 3:
  - DOUT_VALID shows 1,0,1,1 starting 3 cycles later.
  - Pattern is aligned sample-for-sample with DOUT.
- Request CFG_DELAY = 0 in RUN:
  - CFG_ERR pulses for 1 cycle; DELAY unchanged.
  - DOUT_VALID stays continuous.
- CFG_VALID held high with value 9 during SETTLE of a delay-4 change:
  - CFG_READY low for 4 cycles.
  - Request is accepted on the first RUN cycle; DELAY = 9 follows.
- RST_N pulsed low midway through a 15-cycle SETTLE:
  - Outputs return to reset values immediately.
  - DELAY = DEFAULT_DELAY; the SETTLE restarts.

Source files
------------

// File: rtl/delay_line_controller.sv
// ============================================================================
// Module      : delay_line_controller
// Description : Delay-change sequencer and per-sample valid tracker for a
//               variable shift-register delay line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_line_controller #(
    parameter int MAX_DELAY_LENGTH = 16,
    parameter int DEFAULT_DELAY    = 1,
    localparam int DW              = $clog2(MAX_DELAY_LENGTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [DW-1:0] CFG_DELAY,
    input  logic          CFG_VALID,
    output logic          CFG_READY,
    output logic          CFG_ERR,
    input  logic          DIN_VALID,
    output logic [DW-1:0] DELAY,
    output logic          DOUT_VALID,
    output logic          BUSY
);

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [DW-1:0]               cnt_q, cnt_d;
    logic [DW-1:0]               delay_q, delay_d;
    logic [MAX_DELAY_LENGTH-1:0] vsr_q, vsr_d;
    logic                        cfg_err_q, cfg_err_d;
    logic [DW-1:0]               tag_idx;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_SETTLE;
            cnt_q     <= '0;
            delay_q   <= DW'(DEFAULT_DELAY);
            vsr_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            delay_q   <= delay_d;
            vsr_q     <= vsr_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        delay_d   = delay_q;
        cfg_err_d = 1'b0;
        // Tags keep shifting while blanked so they are correct on the first RUN cycle
        vsr_d     = {vsr_q[MAX_DELAY_LENGTH-2:0], DIN_VALID};
        case (state_q)
            ST_SETTLE: begin
                if (cnt_q == delay_q - DW'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            ST_RUN: begin
                if (CFG_VALID) begin
                    if (CFG_DELAY == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        delay_d = CFG_DELAY;
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign tag_idx    = delay_q - DW'(1);
    assign CFG_READY  = (state_q == ST_RUN);
    assign BUSY       = (state_q != ST_RUN);
    assign DOUT_VALID = (state_q == ST_RUN) && vsr_q[tag_idx];
    assign CFG_ERR    = cfg_err_q;
    assign DELAY      = delay_q;

endmodule

`default_nettype wire

// File: tb/tb_delay_line_controller.sv
// ============================================================================
// Module      : tb_delay_line_controller
// Description : Directed plus random stimulus against a cycle-indexed history
//               model of the delay line controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_line_controller;

    localparam int MAXD = 16;
    localparam int DEFD = 1;
    localparam int DW   = $clog2(MAXD);

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [DW-1:0] CFG_DELAY;
    logic          CFG_VALID;
    logic          CFG_READY;
    logic          CFG_ERR;
    logic          DIN_VALID;
    logic [DW-1:0] DELAY;
    logic          DOUT_VALID;
    logic          BUSY;

    delay_line_controller #(
        .MAX_DELAY_LENGTH(MAXD),
        .DEFAULT_DELAY   (DEFD)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CFG_DELAY (CFG_DELAY),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .CFG_ERR   (CFG_ERR),
        .DIN_VALID (DIN_VALID),
        .DELAY     (DELAY),
        .DOUT_VALID(DOUT_VALID),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    // Model: n = cycles since reset release; samp[e] = DIN_VALID taken at edge e
    int   n;
    int   m_delay;
    int   run_start;
    int   err_edge;
    logic samp [0:4095];
    logic          req_pend;
    logic [DW-1:0] req_val;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    endtask

    task automatic model_reset();
        n         = 0;
        m_delay   = DEFD;
        run_start = DEFD;
        err_edge  = -1;
        for (int i = 0; i < 4096; i++) samp[i] = 1'b0;
        req_pend  = 1'b0;
        req_val   = '0;
    endtask

    task automatic check_outputs();
        int  idx;
        bit  ready;
        bit  dv;
        ready = (n >= run_start);
        idx   = n - m_delay + 1;
        dv    = ready && (idx >= 1) && samp[idx];
        chk("ready", int'(CFG_READY), int'(ready));
        chk("busy", int'(BUSY), int'(!ready));
        chk("delay", int'(DELAY), m_delay);
        chk("dout_valid", int'(DOUT_VALID), int'(dv));
        chk("cfg_err", int'(CFG_ERR), int'(n > 0 && err_edge == n));
    endtask

    task automatic check_reset_values();
        chk("rst_ready", int'(CFG_READY), 0);
        chk("rst_busy", int'(BUSY), 1);
        chk("rst_delay", int'(DELAY), DEFD);
        chk("rst_dout_valid", int'(DOUT_VALID), 0);
        chk("rst_cfg_err", int'(CFG_ERR), 0);
    endtask

    // One clock: check current cycle, drive inputs, advance model at the edge
    task automatic cycle(input logic din, input logic new_req, input logic [DW-1:0] val);
        bit acc;
        check_outputs();
        DIN_VALID = din;
        if (!req_pend && new_req) begin
            req_pend = 1'b1;
            req_val  = val;
        end
        CFG_VALID = req_pend;
        CFG_DELAY = req_val;
        acc = (n >= run_start) && req_pend;
        @(posedge CLK);
        n++;
        if (n < 4096) samp[n] = din;
        if (acc) begin
            if (req_val == '0) begin
                err_edge = n;
            end else begin
                m_delay   = int'(req_val);
                run_start = n + int'(req_val);
            end
            req_pend = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic run(input int cycles, input logic din);
        for (int i = 0; i < cycles; i++) cycle(din, 1'b0, '0);
    endtask

    initial begin
        RST_N     = 1'b0;
        CFG_VALID = 1'b0;
        CFG_DELAY = '0;
        DIN_VALID = 1'b1;
        model_reset();
        repeat (2) @(negedge CLK);
        check_reset_values();
        RST_N = 1'b1;

        // Default delay bring-up with continuous input
        run(4, 1'b1);

        // Change to 5: five blanked cycles, then valid again
        cycle(1'b1, 1'b1, DW'(5));
        run(9, 1'b1);

        // Delay 3 with a 1,0,1,1 input pattern
        cycle(1'b1, 1'b1, DW'(3));
        run(4, 1'b1);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        run(5, 1'b0);

        // Illegal zero request: error pulse, no blanking
        run(3, 1'b1);
        cycle(1'b1, 1'b1, '0);
        run(4, 1'b1);

        // Request 9 held off during the settle of a delay-4 change
        cycle(1'b1, 1'b1, DW'(4));
        cycle(1'b1, 1'b1, DW'(9));
        run(14, 1'b1);

        // Reset partway through a 15-cycle settle
        cycle(1'b1, 1'b1, DW'(15));
        run(7, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_values();
        CFG_VALID = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_reset_values();
        model_reset();
        RST_N = 1'b1;
        run(5, 1'b1);

        // Random traffic including repeated and zero delay requests
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  DW'($urandom_range(0, MAXD - 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
